// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline stages.
// The MEM/WB bundle is defined here so every stage sees the same layout.
package cpu_pkg;

    localparam int DATA_W          = 16;
    localparam int REG_W           = 3;
    localparam int CNT_W           = 8;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] pc_plus_2;
        logic [DATA_W-1:0] immediate;
        logic [DATA_W-1:0] slbi_or;
        logic [DATA_W-1:0] comparison;
        logic              memread;
        logic              regwrite;
        logic              compreg;
        logic              lbi;
        logic              slbi;
        logic              jump;
        logic              halt;
        logic [REG_W-1:0]  wreg;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register bank. While disabled the operands hold and
// the valid bit drops, so write-back sees a bubble during a stall.
module mem_wb_latch
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  mem_wb_t d,
    output mem_wb_t q
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: ready/valid data-memory access with upstream stall,
// misalignment/timeout detection and the MEM/WB register.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DATA_W-1:0] ex_pc_plus_2,
    input  logic [DATA_W-1:0] ex_immediate,
    input  logic [DATA_W-1:0] ex_slbi_or,
    input  logic [DATA_W-1:0] ex_comparison,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_regwrite,
    input  logic              ex_compreg,
    input  logic              ex_lbi,
    input  logic              ex_slbi,
    input  logic              ex_jump,
    input  logic              ex_halt,
    input  logic [REG_W-1:0]  ex_wreg,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [DATA_W-1:0] wb_alu_out,
    output logic [DATA_W-1:0] wb_pc_plus_2,
    output logic [DATA_W-1:0] wb_immediate,
    output logic [DATA_W-1:0] wb_slbi_or,
    output logic [DATA_W-1:0] wb_comparison,
    output logic              wb_memread,
    output logic              wb_regwrite,
    output logic              wb_compreg,
    output logic              wb_lbi,
    output logic              wb_slbi,
    output logic              wb_jump,
    output logic              wb_halt,
    output logic [REG_W-1:0]  wb_wreg,
    output logic              err
);

    mem_state_t       state;
    logic [CNT_W-1:0] wait_cnt;

    logic    mem_op;
    logic    misaligned;
    logic    req_c;
    logic    stall_c;
    logic    timeout_now;
    logic    completes;
    mem_wb_t wb_d;
    mem_wb_t wb_q;

    assign mem_op     = ex_valid & (ex_memread | ex_memwrite);
    assign misaligned = (state == IDLE) & mem_op & ex_alu_out[0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req_c       = 1'b0;
        stall_c     = 1'b0;
        timeout_now = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_op && !ex_alu_out[0]) begin
                    req_c   = 1'b1;
                    stall_c = ~dmem_ready;
                end
            end
            WAIT: begin
                if (wait_cnt == CNT_W'(TIMEOUT)) begin
                    timeout_now = 1'b1;
                end else begin
                    req_c   = 1'b1;
                    stall_c = ~dmem_ready;
                end
            end
            default: ;
        endcase
    end

    // Gated by rst so a reset mid-access withdraws the request immediately,
    // even while EX/MEM still presents the memory op.
    assign dmem_req   = req_c & ~rst;
    assign mem_stall  = stall_c & ~rst;
    assign dmem_we    = ex_memwrite;
    assign dmem_addr  = ex_alu_out;
    assign dmem_wdata = ex_wdata;

    assign completes = req_c & dmem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= err | misaligned | timeout_now;
            unique case (state)
                IDLE: begin
                    if (req_c && !dmem_ready) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (timeout_now || dmem_ready) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wb_d            = '0;
        wb_d.valid      = ex_valid;
        wb_d.mem_data   = (completes && ex_memread) ? dmem_rdata : '0;
        wb_d.alu_out    = ex_alu_out;
        wb_d.pc_plus_2  = ex_pc_plus_2;
        wb_d.immediate  = ex_immediate;
        wb_d.slbi_or    = ex_slbi_or;
        wb_d.comparison = ex_comparison;
        wb_d.memread    = ex_memread & ~misaligned;
        wb_d.regwrite   = ex_regwrite & ~misaligned & ~timeout_now;
        wb_d.compreg    = ex_compreg;
        wb_d.lbi        = ex_lbi;
        wb_d.slbi       = ex_slbi;
        wb_d.jump       = ex_jump;
        wb_d.halt       = ex_halt;
        wb_d.wreg       = ex_wreg;
    end

    mem_wb_latch u_mem_wb_latch (
        .clk (clk),
        .rst (rst),
        .en  (~stall_c),
        .d   (wb_d),
        .q   (wb_q)
    );

    assign wb_valid      = wb_q.valid;
    assign wb_mem_data   = wb_q.mem_data;
    assign wb_alu_out    = wb_q.alu_out;
    assign wb_pc_plus_2  = wb_q.pc_plus_2;
    assign wb_immediate  = wb_q.immediate;
    assign wb_slbi_or    = wb_q.slbi_or;
    assign wb_comparison = wb_q.comparison;
    assign wb_memread    = wb_q.memread;
    assign wb_regwrite   = wb_q.regwrite;
    assign wb_compreg    = wb_q.compreg;
    assign wb_lbi        = wb_q.lbi;
    assign wb_slbi       = wb_q.slbi;
    assign wb_jump       = wb_q.jump;
    assign wb_halt       = wb_q.halt;
    assign wb_wreg       = wb_q.wreg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: the bench acts as the data memory
// and predicts each instruction's handshake and MEM/WB result from its rules.
module tb_mem_access_stage;
    import cpu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_alu_out, ex_wdata, ex_pc_plus_2, ex_immediate, ex_slbi_or, ex_comparison;
    logic        ex_memread, ex_memwrite, ex_regwrite, ex_compreg, ex_lbi, ex_slbi, ex_jump, ex_halt;
    logic [2:0]  ex_wreg;
    logic        mem_stall, dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [15:0] dmem_rdata;
    logic        wb_valid;
    logic [15:0] wb_mem_data, wb_alu_out, wb_pc_plus_2, wb_immediate, wb_slbi_or, wb_comparison;
    logic        wb_memread, wb_regwrite, wb_compreg, wb_lbi, wb_slbi, wb_jump, wb_halt;
    logic [2:0]  wb_wreg;
    logic        err;

    int errors = 0;
    int checks = 0;
    logic err_exp = 1'b0;

    typedef struct {
        logic        valid;
        logic [15:0] alu, wdata, pc2, imm, slbi_or, cmp;
        logic        rd, wr, rg, compreg, lbi, slbi, jump, halt;
        logic [2:0]  wreg;
    } instr_t;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_wdata(ex_wdata),
        .ex_pc_plus_2(ex_pc_plus_2), .ex_immediate(ex_immediate),
        .ex_slbi_or(ex_slbi_or), .ex_comparison(ex_comparison),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
        .ex_compreg(ex_compreg), .ex_lbi(ex_lbi), .ex_slbi(ex_slbi),
        .ex_jump(ex_jump), .ex_halt(ex_halt), .ex_wreg(ex_wreg),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_mem_data(wb_mem_data), .wb_alu_out(wb_alu_out),
        .wb_pc_plus_2(wb_pc_plus_2), .wb_immediate(wb_immediate),
        .wb_slbi_or(wb_slbi_or), .wb_comparison(wb_comparison),
        .wb_memread(wb_memread), .wb_regwrite(wb_regwrite), .wb_compreg(wb_compreg),
        .wb_lbi(wb_lbi), .wb_slbi(wb_slbi), .wb_jump(wb_jump), .wb_halt(wb_halt),
        .wb_wreg(wb_wreg), .err(err)
    );

    logic [106:0] wb_obs;
    assign wb_obs = {wb_valid, wb_mem_data, wb_alu_out, wb_pc_plus_2, wb_immediate,
                     wb_slbi_or, wb_comparison, wb_memread, wb_regwrite, wb_compreg,
                     wb_lbi, wb_slbi, wb_jump, wb_halt, wb_wreg};

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        ex_valid = i.valid;  ex_alu_out = i.alu;  ex_wdata = i.wdata;
        ex_pc_plus_2 = i.pc2; ex_immediate = i.imm; ex_slbi_or = i.slbi_or;
        ex_comparison = i.cmp; ex_memread = i.rd; ex_memwrite = i.wr;
        ex_regwrite = i.rg;  ex_compreg = i.compreg; ex_lbi = i.lbi;
        ex_slbi = i.slbi;    ex_jump = i.jump; ex_halt = i.halt; ex_wreg = i.wreg;
    endtask

    function automatic instr_t blank();
        instr_t i;
        i = '{default: '0};
        return i;
    endfunction

    // lat = cycle (1-based) on which the memory answers; 0 = never answers.
    task automatic run_instr(input instr_t i, input int lat);
        logic         memop, mis, to, rq, st;
        int           n;
        logic [15:0]  rcap;
        logic [106:0] exp;
        memop = i.valid & (i.rd | i.wr);
        mis   = memop & i.alu[0];
        to    = memop & !mis & (lat == 0 || lat > TO + 1);
        n     = (!memop || mis) ? 1 : (to ? TO + 2 : lat);
        rcap  = '0;
        drive(i);
        for (int c = 1; c <= n; c++) begin
            dmem_ready = memop && !mis && !to && (c == lat);
            dmem_rdata = 16'($urandom);
            if (dmem_ready) rcap = dmem_rdata;
            @(negedge clk);
            rq = memop & !mis & !(to && c == n);
            st = memop & !mis & (c < n);
            check("dmem_req", dmem_req, rq);
            check("mem_stall", mem_stall, st);
            if (rq) begin
                check("dmem_addr", dmem_addr, i.alu);
                check("dmem_wdata", dmem_wdata, i.wdata);
                check("dmem_we", dmem_we, i.wr);
            end
            if (c > 1) check("wb_valid_bubble", wb_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        dmem_ready = 1'b0;
        exp = {i.valid,
               (memop && !mis && !to && i.rd) ? rcap : 16'h0000,
               i.alu, i.pc2, i.imm, i.slbi_or, i.cmp,
               i.rd & ~mis, i.rg & ~mis & ~to,
               i.compreg, i.lbi, i.slbi, i.jump, i.halt, i.wreg};
        check("wb_bundle", wb_obs, exp);
        err_exp = err_exp | mis | to;
        check("err", err, err_exp);
    endtask

    task automatic do_reset();
        drive(blank());
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb", wb_obs, 107'd0);
        check("rst_err", err, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        rst = 1'b0;
        err_exp = 1'b0;
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        int     kind;
        i.valid   = ($urandom_range(0, 9) != 0);
        kind      = $urandom_range(0, 3);
        i.rd      = (kind == 2);
        i.wr      = (kind == 3);
        i.alu     = 16'($urandom);
        if (kind >= 2 && $urandom_range(0, 9) != 0) i.alu[0] = 1'b0;
        i.wdata   = 16'($urandom);
        i.pc2     = 16'($urandom);
        i.imm     = 16'($urandom);
        i.slbi_or = 16'($urandom);
        i.cmp     = 16'($urandom);
        i.rg      = 1'($urandom);
        i.compreg = 1'($urandom);
        i.lbi     = 1'($urandom);
        i.slbi    = 1'($urandom);
        i.jump    = 1'($urandom);
        i.halt    = 1'($urandom);
        i.wreg    = 3'($urandom);
        return i;
    endfunction

    initial begin
        instr_t i;
        do_reset();

        // ALU op, then aligned zero-wait load, then three-cycle store.
        i = blank(); i.valid = 1; i.alu = 16'h1234; i.rg = 1; i.wreg = 3'd5;
        run_instr(i, 1);
        i = blank(); i.valid = 1; i.alu = 16'h0040; i.rd = 1; i.rg = 1; i.wreg = 3'd2;
        run_instr(i, 1);
        i = blank(); i.valid = 1; i.alu = 16'h0010; i.wr = 1; i.wdata = 16'hA5A5;
        run_instr(i, 3);
        // Latest possible answer before timeout, then a true timeout.
        i = blank(); i.valid = 1; i.alu = 16'h0020; i.rd = 1; i.rg = 1;
        run_instr(i, TO + 1);
        i = blank(); i.valid = 1; i.alu = 16'h0022; i.rd = 1; i.rg = 1; i.wreg = 3'd7;
        run_instr(i, 0);
        i = blank(); i.valid = 1; i.alu = 16'h0024; i.rd = 1; i.rg = 1;
        run_instr(i, 2);
        do_reset();

        // Misaligned load; err must stay set across later clean instructions.
        i = blank(); i.valid = 1; i.alu = 16'h0011; i.rd = 1; i.rg = 1;
        run_instr(i, 1);
        i = blank(); i.valid = 1; i.alu = 16'h0002; i.rg = 1;
        run_instr(i, 1);
        do_reset();

        // Reset asserted while waiting on memory.
        i = blank(); i.valid = 1; i.alu = 16'h0040; i.rd = 1; i.rg = 1;
        drive(i);
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req", dmem_req, 1'b0);
        check("midrst_stall", mem_stall, 1'b0);
        check("midrst_wb", wb_obs, 107'd0);
        drive(blank());
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 16'hDEAD;
        @(negedge clk);
        check("late_ready_req", dmem_req, 1'b0);
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
        check("late_ready_wb", wb_obs, 107'd0);
        check("late_ready_err", err, 1'b0);

        for (int k = 0; k < 200; k++) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO + 1);
            run_instr(rand_instr(), lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
